// File: rtl/mpadder_pkg.sv
// rtl/mpadder_pkg.sv - shared widths and FSM state encodings for mpadder_arbiter
//   OP_W    : adder operand width
//   RES_W   : adder result width (carry/borrow in the MSB)
//   state_t : FSM state type, IDLE/ISSUE/WAIT/RESP encodings
package mpadder_pkg;

  localparam int OP_W  = 1027;
  localparam int RES_W = OP_W + 1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/mpadder_arbiter_if.sv
// rtl/mpadder_arbiter_if.sv - bus between the arbiter and the single mpadder instance
//   start    : 1-cycle start pulse to the adder
//   subtract : 1 = in_a - in_b, 0 = in_a + in_b
//   in_a     : operand A, held stable while the adder runs
//   in_b     : operand B, held stable while the adder runs
//   result   : adder result, MSB is carry/borrow
//   done     : adder completion pulse
//   master   : arbiter side, slave : adder side
interface mpadder_arbiter_if;
  import mpadder_pkg::*;

  logic             start;
  logic             subtract;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [RES_W-1:0] result;
  logic             done;

  modport master (
    output start,
    output subtract,
    output in_a,
    output in_b,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  subtract,
    input  in_a,
    input  in_b,
    output result,
    output done
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner selection
//   req    : in,  per-requester request bits
//   ptr    : in,  highest-priority index for this pick
//   any    : out, at least one request is set
//   onehot : out, one-hot winner
//   index  : out, binary winner index
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      index
);

  // (base + off) mod NUM_REQ, valid for off < NUM_REQ and base < NUM_REQ
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return IW'(s);
  endfunction

  logic [IW-1:0] cand;

  // Scan starting at ptr; the first set bit found wins.
  always_comb begin
    any    = 1'b0;
    onehot = '0;
    index  = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(ptr, i);
      if (!any && req[cand]) begin
        any           = 1'b1;
        index         = cand;
        onehot[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpadder_arbiter.sv
// rtl/mpadder_arbiter.sv - round-robin sharing of one mpadder among NUM_REQ requesters
//   clk, reset   : clock, synchronous active-high reset
//   req          : in,  per-requester level request, held until own gnt
//   req_sub      : in,  per-requester subtract select
//   req_a, req_b : in,  packed operands, requester i at [i*OP_W +: OP_W]
//   gnt          : out, one-hot 1-cycle pulse when operands are captured
//   rsp_valid    : out, 1-cycle pulse, rsp_id/rsp_result valid
//   rsp_id       : out, owner of rsp_result
//   rsp_result   : out, adder result (0 after a timeout)
//   busy         : out, high from ISSUE through RESP
//   err_timeout  : out, sticky, adder missed its done deadline
//   add          : adder bus (master side)
module mpadder_arbiter
  import mpadder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_sub,
  input  logic [NUM_REQ*OP_W-1:0]    req_a,
  input  logic [NUM_REQ*OP_W-1:0]    req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [RES_W-1:0]           rsp_result,
  output logic                       busy,
  output logic                       err_timeout,
  mpadder_arbiter_if.master          add
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  // Give up once this many WAIT cycles have elapsed without done.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [IW-1:0]   ptr_next;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;

  logic [OP_W-1:0] sel_a;
  logic [OP_W-1:0] sel_b;
  logic            sel_sub;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .onehot (pick_oh),
    .index  (pick_idx)
  );

  // AND-OR operand mux driven by the one-hot winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_a   = req_a[i*OP_W +: OP_W];
        sel_b   = req_b[i*OP_W +: OP_W];
        sel_sub = req_sub[i];
      end
    end
  end

  assign cnt_inc  = cnt + 1'b1;
  assign ptr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      add.start    <= 1'b0;
      add.subtract <= 1'b0;
      add.in_a     <= '0;
      add.in_b     <= '0;
    end else begin
      gnt       <= '0;
      add.start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner        <= pick_idx;
            gnt          <= pick_oh;
            add.start    <= 1'b1;
            add.subtract <= sel_sub;
            add.in_a     <= sel_a;
            add.in_b     <= sel_b;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // add.done during this cycle belongs to a previous op; ignore it.
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (add.done) begin
            rsp_result <= add.result;
            rsp_id     <= owner;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cnt_inc == TO_LAST) begin
            err_timeout <= 1'b1;
            rsp_result  <= '0;
            rsp_id      <= owner;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ptr   <= ptr_next;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// tb/tb_mpadder_arbiter.sv - scoreboard bench for mpadder_arbiter with a behavioural adder
module tb_mpadder_arbiter;
  import mpadder_pkg::*;

  localparam int N = 4;

  logic                clk;
  logic                reset;
  logic [N-1:0]        req;
  logic [N-1:0]        req_sub;
  logic [N*OP_W-1:0]   req_a;
  logic [N*OP_W-1:0]   req_b;
  logic [N-1:0]        gnt;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [RES_W-1:0]    rsp_result;
  logic                busy;
  logic                err_timeout;

  mpadder_arbiter_if bus ();

  mpadder_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_sub     (req_sub),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .busy        (busy),
    .err_timeout (err_timeout),
    .add         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int              id;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            sub;
  } gnt_exp_t;

  typedef struct {
    int               id;
    logic [RES_W-1:0] res;
    int               lat;
    logic             err;
  } rsp_exp_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];

  int n_checks;
  int n_fail;
  int n_rsp;
  int n_starts;
  int n_issued;
  int cyc;
  int start_cyc;
  int done_delay;
  int pending;
  logic hold_req;
  logic stale_next;

  logic [OP_W-1:0] m_a, m_b;
  logic            m_sub;

  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural mpadder: done pulses done_delay cycles after start (never if < 0).
  initial begin
    bus.done   = 1'b0;
    bus.result = '0;
    pending    = -1;
    n_starts   = 0;
    start_cyc  = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.done = 1'b0;
      if (reset) begin
        pending = -1;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            bus.done   = 1'b1;
            bus.result = m_sub ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
            pending    = -1;
          end
        end
        if (bus.start) begin
          m_a       = bus.in_a;
          m_b       = bus.in_b;
          m_sub     = bus.subtract;
          start_cyc = cyc;
          n_starts++;
          pending   = done_delay;
          if (stale_next) begin
            bus.done   = 1'b1;
            bus.result = {RES_W{1'b1}};
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents gnt or rsp_valid.
  gnt_exp_t        ge;
  rsp_exp_t        re;
  logic [N-1:0]    exp_oh;
  logic [OP_W-1:0] last_a, last_b;
  logic            last_sub;

  initial begin
    n_rsp = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gnt != '0) begin
          if (gnt_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_unexpected: got gnt=%b, required no grant", gnt);
          end else begin
            ge = gnt_q.pop_front();
            exp_oh = '0;
            exp_oh[ge.id] = 1'b1;
            chk("gnt_onehot", gnt, exp_oh);
            chk("gnt_add_start", bus.start, 1'b1);
            chk("gnt_add_subtract", bus.subtract, ge.sub);
            chk("gnt_add_in_a", bus.in_a, ge.a);
            chk("gnt_add_in_b", bus.in_b, ge.b);
            last_a   = ge.a;
            last_b   = ge.b;
            last_sub = ge.sub;
          end
        end
        if (rsp_valid) begin
          n_rsp++;
          if (rsp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid with id %0d, required none", rsp_id);
          end else begin
            re = rsp_q.pop_front();
            chk("rsp_id", rsp_id, re.id);
            chk("rsp_result", rsp_result, re.res);
            chk("rsp_latency_from_start", cyc - start_cyc, re.lat);
            chk("rsp_err_timeout", err_timeout, re.err);
            chk("operands_held", (bus.in_a == last_a) && (bus.in_b == last_b) && (bus.subtract == last_sub), 1'b1);
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic sub);
    req_a[i*OP_W +: OP_W] = a;
    req_b[i*OP_W +: OP_W] = b;
    req_sub[i]            = sub;
  endtask

  task automatic issue_gnt(input int id, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic sub);
    gnt_exp_t g;
    set_op(id, a, b, sub);
    g.id = id; g.a = a; g.b = b; g.sub = sub;
    gnt_q.push_back(g);
    n_issued++;
  endtask

  task automatic issue_exp(input int id, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic sub,
                           input logic [RES_W-1:0] res, input int lat, input logic err);
    rsp_exp_t r;
    issue_gnt(id, a, b, sub);
    r.id = id; r.res = res; r.lat = lat; r.err = err;
    rsp_q.push_back(r);
  endtask

  // One cycle of requester behaviour: drop a request once it has been granted.
  task automatic step_cycle();
    @(negedge clk);
    if (!hold_req) req = req & ~gnt;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k;
    k = 0;
    while (n_rsp < target && k < budget) begin
      step_cycle();
      k++;
    end
    if (n_rsp < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_wait: got %0d responses, required %0d within %0d cycles", n_rsp, target, budget);
    end
  endtask

  task automatic wait_gnt_q(input int left, input int budget);
    int k;
    k = 0;
    while (gnt_q.size() > left && k < budget) begin
      step_cycle();
      k++;
    end
    if (gnt_q.size() > left) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_wait: got %0d grants pending, required %0d within %0d cycles", gnt_q.size(), left, budget);
    end
  endtask

  task automatic check_idle_outputs();
    chk("idle_gnt", gnt, '0);
    chk("idle_rsp_valid", rsp_valid, '0);
    chk("idle_rsp_id", rsp_id, '0);
    chk("idle_rsp_result", rsp_result, '0);
    chk("idle_busy", busy, '0);
    chk("idle_err_timeout", err_timeout, '0);
    chk("idle_add_start", bus.start, '0);
    chk("idle_add_subtract", bus.subtract, '0);
    chk("idle_add_in_a", bus.in_a, '0);
    chk("idle_add_in_b", bus.in_b, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

  initial begin
    int tgt;
    n_checks = 0; n_fail = 0; n_issued = 0; cyc = 0;
    reset = 1'b1; req = '0; req_sub = '0; req_a = '0; req_b = '0;
    hold_req = 1'b0; stale_next = 1'b0; done_delay = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs();
    reset = 1'b0;
    step_cycle();

    // 5 + 3 = 8, done two cycles after start
    done_delay = 2;
    tgt = n_rsp + 1;
    issue_exp(0, 5, 3, 1'b0, 8, 3, 1'b0);
    req[0] = 1'b1;
    wait_rsp(tgt, 40);

    // 3 - 5 over 1028 bits: all ones except bit 0 (borrow in MSB)
    done_delay = 3;
    tgt = n_rsp + 1;
    issue_exp(2, 3, 5, 1'b1, {{(RES_W-1){1'b1}}, 1'b0}, 4, 1'b0);
    req[2] = 1'b1;
    wait_rsp(tgt, 40);

    // adder never answers: response 16 cycles after start, result 0, sticky error
    done_delay = -1;
    tgt = n_rsp + 1;
    issue_exp(3, 11, 22, 1'b0, 0, 16, 1'b1);
    req[3] = 1'b1;
    wait_rsp(tgt, 60);

    // next op still completes, error stays set; leaves ptr at 3
    done_delay = 1;
    tgt = n_rsp + 1;
    issue_exp(2, 7, 9, 1'b0, 16, 2, 1'b1);
    req[2] = 1'b1;
    wait_rsp(tgt, 40);

    // reset during WAIT abandons the op
    done_delay = 10;
    issue_gnt(3, 1, 2, 1'b0);
    req[3] = 1'b1;
    wait_gnt_q(0, 20);
    step_cycle();
    step_cycle();
    reset = 1'b1;
    req = '0;
    step_cycle();
    check_idle_outputs();
    reset = 1'b0;
    repeat (15) step_cycle();

    // ptr back at 0: requester 2 beats requester 3
    done_delay = 1;
    tgt = n_rsp + 2;
    issue_exp(2, 40, 2, 1'b1, 38, 2, 1'b0);
    issue_exp(3, 50, 60, 1'b0, 110, 2, 1'b0);
    req = 4'b1100;
    wait_rsp(tgt, 60);

    // all requests held: grant order 0,1,2,3,0,1,2,3
    done_delay = 1;
    tgt = n_rsp + 8;
    for (int k = 0; k < 8; k++) begin
      issue_exp(k % 4, k % 4 + 1, 16, 1'b0, 17 + k % 4, 2, 1'b0);
    end
    hold_req = 1'b1;
    req = 4'b1111;
    wait_gnt_q(0, 120);
    req = '0;
    hold_req = 1'b0;
    wait_rsp(tgt, 40);

    // req[1] withdrawn before capture; stale done in ISSUE ignored
    done_delay = 4;
    tgt = n_rsp + 2;
    issue_exp(0, 20, 22, 1'b0, 42, 5, 1'b0);
    set_op(1, 1, 1, 1'b0);
    issue_exp(3, 100, 200, 1'b0, 300, 2, 1'b0);
    req[0] = 1'b1;
    wait_gnt_q(1, 20);
    done_delay = 1;
    stale_next = 1'b1;
    req[1] = 1'b1;
    req[3] = 1'b1;
    step_cycle();
    step_cycle();
    req[1] = 1'b0;
    wait_gnt_q(0, 40);
    stale_next = 1'b0;
    wait_rsp(tgt, 40);
    repeat (5) step_cycle();

    chk("add_start_count", n_starts, n_issued);
    chk("gnt_queue_drained", gnt_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
